fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding IMEM request, registered decoder
// output backed by a one-entry skid buffer, with branch/jump redirect handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        instr_valid_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_q, state_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        discard_q, discard_d;
   logic        skid_vld_q, skid_vld_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        out_vld_q, out_vld_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        can_load;

   // The output register may take new data when it is empty or being consumed.
   assign can_load = !out_vld_q || !stall;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      discard_d    = discard_q;
      skid_vld_d   = skid_vld_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      out_vld_d    = out_vld_q;

      if (!stall) begin
         out_vld_d = 1'b0;
         instr_d   = NOP_INSTR;
      end

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_req_ready) begin
               state_d    = S_WAIT;
               fetch_pc_d = pc_q;
               pc_d       = pc_q + 32'd4;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = S_REQ;
               if (discard_q) begin
                  discard_d = 1'b0;
               end else if (can_load) begin
                  instr_d   = imem_rsp_data;
                  pc_out_d  = fetch_pc_q;
                  out_vld_d = 1'b1;
               end else begin
                  skid_vld_d   = 1'b1;
                  skid_instr_d = imem_rsp_data;
                  skid_pc_d    = fetch_pc_q;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall) begin
               state_d    = S_REQ;
               skid_vld_d = 1'b0;
               if (skid_vld_q) begin
                  instr_d   = skid_instr_q;
                  pc_out_d  = skid_pc_q;
                  out_vld_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides stall, response loading and skid draining.
      if (redirect_valid) begin
         pc_d       = redirect_pc & ~32'd3;
         out_vld_d  = 1'b0;
         instr_d    = NOP_INSTR;
         pc_out_d   = pc_out_q;
         skid_vld_d = 1'b0;
         case (state_q)
            S_REQ: begin
               state_d   = imem_req_ready ? S_WAIT : S_REQ;
               discard_d = imem_req_ready;
            end
            S_WAIT: begin
               state_d   = imem_rsp_valid ? S_REQ : S_WAIT;
               discard_d = !imem_rsp_valid;
            end
            S_HOLD:  state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end

      req_valid_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_valid_q <= 1'b0;
         pc_q        <= RESET_PC;
         discard_q   <= 1'b0;
         skid_vld_q  <= 1'b0;
         out_vld_q   <= 1'b0;
         instr_q     <= NOP_INSTR;
         pc_out_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         pc_q        <= pc_d;
         discard_q   <= discard_d;
         skid_vld_q  <= skid_vld_d;
         out_vld_q   <= out_vld_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
      end
   end

   // Pure data holders; they are only read when the matching control bit is set.
   always_ff @(posedge clk) begin
      fetch_pc_q   <= fetch_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign instr_o        = instr_q;
   assign pc_o           = pc_out_q;
   assign pc4_o          = pc_out_q + 32'd4;
   assign instr_valid_o  = out_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model (sequential pcs, redirect targets, memory image).
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc4_o;
   logic        instr_valid_o;

   int nvec = 0;
   int nerr = 0;

   // Memory model state
   bit          mem_rand;
   bit          mem_rdy;
   int          mem_lat;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   bit          outst;
   bit          acc_now;
   logic [31:0] acc_addr;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall(stall), .instr_o(instr_o),
      .pc_o(pc_o), .pc4_o(pc4_o), .instr_valid_o(instr_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One cycle: go to the falling edge, then act as the instruction memory.
   task automatic step();
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      acc_now = 1'b0;
      outst = pend;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
         end
      end else if (mem_rand && $urandom_range(0, 3) == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hBAD0_0000 ^ 32'($urandom_range(0, 65535));
      end
      if (mem_rand) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         mem_lat = $urandom_range(1, 3);
      end else begin
         imem_req_ready = mem_rdy;
      end
      if (imem_req_valid && imem_req_ready && !rst) begin
         pend = 1'b1; pend_cnt = mem_lat; pend_addr = imem_req_addr;
         acc_now = 1'b1; acc_addr = imem_req_addr;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
      pend = 1'b0; mem_rand = 1'b0; mem_rdy = 1'b1; mem_lat = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
      nvec++; if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin nerr++; $display("FAIL rst_instr got v=%b i=%h want v=0 i=%h", instr_valid_o, instr_o, NOP); end
      nvec++; if (pc_o !== 32'd0 || pc4_o !== 32'd4) begin nerr++; $display("FAIL rst_pc got pc=%h pc4=%h want 0/4", pc_o, pc4_o); end
      rst = 1'b0;
      #1;
      nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL idle_after_release got=%b want=0", imem_req_valid); end
      step();
      nvec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin nerr++; $display("FAIL first_req got v=%b a=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      logic [31:0] accs[$];
      int got, first_i, last_i;
      apply_reset();
      exp_pc = RST_PC; got = 0; first_i = -1; last_i = -1;
      for (int i = 0; i < 30 && got < 3; i++) begin
         step();
         if (acc_now) accs.push_back(acc_addr);
         if (instr_valid_o) begin
            nvec++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc) || pc4_o !== exp_pc + 32'd4) begin
               nerr++; $display("FAIL seq_out got pc=%h i=%h pc4=%h want pc=%h i=%h", pc_o, instr_o, pc4_o, exp_pc, mem_word(exp_pc));
            end
            if (first_i < 0) first_i = i;
            last_i = i;
            exp_pc += 32'd4; got++;
         end
      end
      nvec++; if (got != 3) begin nerr++; $display("FAIL seq_count got=%0d want=3", got); end
      nvec++; if (first_i != 2 || last_i != 6) begin nerr++; $display("FAIL seq_timing got first=%0d last=%0d want 2/6", first_i, last_i); end
      nvec++;
      if (accs.size() < 3 || accs[0] !== 32'h0 || accs[1] !== 32'h4 || accs[2] !== 32'h8) begin
         nerr++; $display("FAIL seq_req_addrs got n=%0d want 0,4,8", accs.size());
      end
   endtask

   task automatic test_skid();
      bit found;
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (instr_valid_o && pc_o == 32'h4) found = 1'b1;
      end
      nvec++; if (!found) begin nerr++; $display("FAIL skid_setup got none want pc 00000004"); end
      stall = 1'b1;
      step();
      nvec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h4) begin nerr++; $display("FAIL skid_hold1 got v=%b pc=%h want 1/4", instr_valid_o, pc_o); end
      step();
      nvec++;
      if (imem_req_valid !== 1'b0 || instr_valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== mem_word(32'h4)) begin
         nerr++; $display("FAIL skid_hold2 got req=%b v=%b pc=%h i=%h want 0/1/4", imem_req_valid, instr_valid_o, pc_o, instr_o);
      end
      step();
      nvec++; if (imem_req_valid !== 1'b0 || pc_o !== 32'h4) begin nerr++; $display("FAIL skid_hold3 got req=%b pc=%h want 0/4", imem_req_valid, pc_o); end
      stall = 1'b0;
      step();
      nvec++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== mem_word(32'h8) || pc4_o !== 32'hC) begin
         nerr++; $display("FAIL skid_release got v=%b pc=%h i=%h want 1/8/%h", instr_valid_o, pc_o, instr_o, mem_word(32'h8));
      end
   endtask

   task automatic test_redirect_wait();
      bit got, seen;
      logic [31:0] first_acc;
      apply_reset();
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (instr_valid_o && pc_o == 32'h0) got = 1'b1;
      end
      mem_lat = 3;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (acc_now && acc_addr == 32'h8) got = 1'b1;
      end
      nvec++; if (!got) begin nerr++; $display("FAIL rw_setup got none want accept 00000008"); end
      mem_lat = 1;
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_valid = 1'b0;
      nvec++;
      if (instr_valid_o !== 1'b0 || instr_o !== NOP || imem_req_valid !== 1'b0) begin
         nerr++; $display("FAIL rw_after got v=%b i=%h req=%b want 0/%h/0", instr_valid_o, instr_o, imem_req_valid, NOP);
      end
      got = 1'b0; seen = 1'b0; first_acc = 32'hFFFF_FFFF;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (acc_now && !seen) begin seen = 1'b1; first_acc = acc_addr; end
         if (instr_valid_o) begin
            got = 1'b1;
            nvec++;
            if (pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin
               nerr++; $display("FAIL rw_first_out got pc=%h i=%h want 00000100/%h", pc_o, instr_o, mem_word(32'h100));
            end
         end
      end
      nvec++; if (first_acc !== 32'h100) begin nerr++; $display("FAIL rw_next_req got=%h want=00000100", first_acc); end
      nvec++; if (!got) begin nerr++; $display("FAIL rw_timeout got none want pc 00000100"); end
   endtask

   task automatic test_redirect_ready();
      bit got, seen;
      logic [31:0] first_acc;
      apply_reset();
      step();
      nvec++; if (!acc_now || acc_addr !== RST_PC) begin nerr++; $display("FAIL rr_setup got acc=%b a=%h want 1/%h", acc_now, acc_addr, RST_PC); end
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      step();
      redirect_valid = 1'b0;
      nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rr_after got v=%b want 0", instr_valid_o); end
      got = 1'b0; seen = 1'b0; first_acc = 32'hFFFF_FFFF;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (acc_now && !seen) begin seen = 1'b1; first_acc = acc_addr; end
         if (instr_valid_o) begin
            got = 1'b1;
            nvec++;
            if (pc_o !== 32'h200 || instr_o !== mem_word(32'h200)) begin
               nerr++; $display("FAIL rr_first_out got pc=%h i=%h want 00000200/%h", pc_o, instr_o, mem_word(32'h200));
            end
         end
      end
      nvec++; if (first_acc !== 32'h200) begin nerr++; $display("FAIL rr_next_req got=%h want=00000200", first_acc); end
      nvec++; if (!got) begin nerr++; $display("FAIL rr_timeout got none want pc 00000200"); end
   endtask

   task automatic test_backpressure();
      bit got;
      apply_reset();
      mem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || acc_now) begin
            nerr++; $display("FAIL bp_stable[%0d] got v=%b a=%h want 1/%h", i, imem_req_valid, imem_req_addr, RST_PC);
         end
      end
      mem_rdy = 1'b1;
      step();
      nvec++; if (!acc_now || acc_addr !== RST_PC) begin nerr++; $display("FAIL bp_accept got acc=%b a=%h want 1/%h", acc_now, acc_addr, RST_PC); end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (acc_now) begin
            got = 1'b1;
            nvec++; if (acc_addr !== RST_PC + 32'd4) begin nerr++; $display("FAIL bp_next got=%h want=%h", acc_addr, RST_PC + 32'd4); end
         end
      end
      nvec++; if (!got) begin nerr++; $display("FAIL bp_timeout got none want second request"); end
   endtask

   task automatic test_reset_mid_wait();
      bit got;
      apply_reset();
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (instr_valid_o && pc_o == 32'h4) got = 1'b1;
      end
      stall = 1'b1;
      step();
      rst = 1'b1;
      #1;
      nvec++;
      if (imem_req_valid !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 32'd0) begin
         nerr++; $display("FAIL rmw_async got req=%b v=%b i=%h pc=%h want 0/0/%h/0", imem_req_valid, instr_valid_o, instr_o, pc_o, NOP);
      end
      stall = 1'b0;
      pend = 1'b0;
      step();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      rst = 1'b0;
      step();
      nvec++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || instr_valid_o !== 1'b0) begin
         nerr++; $display("FAIL rmw_release got req=%b a=%h v=%b want 1/%h/0", imem_req_valid, imem_req_addr, instr_valid_o, RST_PC);
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (instr_valid_o) begin
            got = 1'b1;
            nvec++;
            if (pc_o !== RST_PC || instr_o !== mem_word(RST_PC)) begin
               nerr++; $display("FAIL rmw_first_out got pc=%h i=%h want %h/%h", pc_o, instr_o, RST_PC, mem_word(RST_PC));
            end
         end
      end
      nvec++; if (!got) begin nerr++; $display("FAIL rmw_timeout got none want first instruction"); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, tgt, p_pc, p_instr, p_addr;
      bit p_valid, p_stall, p_redir, p_reqv, p_rdy;
      int ncons;
      apply_reset();
      mem_rand = 1'b1;
      exp_pc = RST_PC; ncons = 0;
      p_valid = 0; p_stall = 0; p_redir = 0; p_reqv = 0; p_rdy = 0;
      p_pc = 0; p_instr = 0; p_addr = 0;
      for (int i = 0; i < 1500; i++) begin
         step();
         nvec++; if (pc4_o !== pc_o + 32'd4) begin nerr++; $display("FAIL rnd_pc4 c=%0d got=%h want=%h", i, pc4_o, pc_o + 32'd4); end
         if (!instr_valid_o) begin
            nvec++; if (instr_o !== NOP) begin nerr++; $display("FAIL rnd_nop c=%0d got=%h want=%h", i, instr_o, NOP); end
         end
         if (p_redir) begin
            nvec++; if (instr_valid_o !== 1'b0) begin nerr++; $display("FAIL rnd_redir_kill c=%0d got v=%b want 0", i, instr_valid_o); end
         end else if (p_valid && p_stall) begin
            nvec++;
            if (instr_valid_o !== 1'b1 || pc_o !== p_pc || instr_o !== p_instr) begin
               nerr++; $display("FAIL rnd_hold c=%0d got v=%b pc=%h i=%h want 1/%h/%h", i, instr_valid_o, pc_o, instr_o, p_pc, p_instr);
            end
         end
         if (p_reqv && !p_rdy && !p_redir) begin
            nvec++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== p_addr) begin
               nerr++; $display("FAIL rnd_req_stable c=%0d got v=%b a=%h want 1/%h", i, imem_req_valid, imem_req_addr, p_addr);
            end
         end
         if (outst) begin
            nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rnd_one_outstanding c=%0d got req=1 want 0", i); end
         end
         if (imem_req_valid) begin
            nvec++; if (imem_req_addr[1:0] !== 2'b00) begin nerr++; $display("FAIL rnd_align c=%0d got=%h", i, imem_req_addr); end
         end

         stall = ($urandom_range(0, 2) == 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         if (redirect_valid) begin
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 4095));
            redirect_pc = tgt;
         end
         if (instr_valid_o && !stall && !redirect_valid) begin
            nvec++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
               nerr++; $display("FAIL rnd_consume c=%0d got pc=%h i=%h want %h/%h", i, pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
            exp_pc += 32'd4;
            ncons++;
         end
         if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
         p_valid = instr_valid_o; p_stall = stall; p_redir = redirect_valid;
         p_pc = pc_o; p_instr = instr_o;
         p_reqv = imem_req_valid; p_rdy = imem_req_ready; p_addr = imem_req_addr;
      end
      redirect_valid = 1'b0; stall = 1'b0; mem_rand = 1'b0;
      nvec++; if (ncons < 50) begin nerr++; $display("FAIL rnd_progress got=%0d want>=50", ncons); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
      mem_rand = 1'b0; mem_rdy = 1'b1; mem_lat = 1; pend = 1'b0; pend_cnt = 0;
      pend_addr = 32'd0; outst = 1'b0; acc_now = 1'b0; acc_addr = 32'd0;
      test_reset();
      test_sequential();
      test_skid();
      test_redirect_wait();
      test_redirect_ready();
      test_backpressure();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
